// File: rtl/top_bus.sv
// Four-port packet interconnect: per-device ingress/egress FIFOs joined by a
// round-robin arbiter that moves one unicast or broadcast packet per clock.
module top_bus #(
    parameter int         PCKG_SZ   = 65,
    parameter int         DEPTH     = 8,
    parameter logic [2:0] BROADCAST = 3'b111
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_device0,
    input  logic               push_device1,
    input  logic               push_device2,
    input  logic               push_device3,
    input  logic [PCKG_SZ-1:0] D_push_device0,
    input  logic [PCKG_SZ-1:0] D_push_device1,
    input  logic [PCKG_SZ-1:0] D_push_device2,
    input  logic [PCKG_SZ-1:0] D_push_device3,
    input  logic               pop_device0,
    input  logic               pop_device1,
    input  logic               pop_device2,
    input  logic               pop_device3,
    output logic [PCKG_SZ-1:0] D_pop_device0,
    output logic [PCKG_SZ-1:0] D_pop_device1,
    output logic [PCKG_SZ-1:0] D_pop_device2,
    output logic [PCKG_SZ-1:0] D_pop_device3,
    output logic               pndng_device0,
    output logic               pndng_device1,
    output logic               pndng_device2,
    output logic               pndng_device3
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0]   cnt_t;
    typedef logic [AW-1:0] ptr_t;

    logic [3:0]         push;
    logic [3:0]         pop;
    logic [PCKG_SZ-1:0] din  [4];
    logic [PCKG_SZ-1:0] dout [4];
    logic [3:0]         pndng;

    assign push    = {push_device3, push_device2, push_device1, push_device0};
    assign pop     = {pop_device3, pop_device2, pop_device1, pop_device0};
    assign din[0]  = D_push_device0;
    assign din[1]  = D_push_device1;
    assign din[2]  = D_push_device2;
    assign din[3]  = D_push_device3;

    assign D_pop_device0 = dout[0];
    assign D_pop_device1 = dout[1];
    assign D_pop_device2 = dout[2];
    assign D_pop_device3 = dout[3];
    assign pndng_device0 = pndng[0];
    assign pndng_device1 = pndng[1];
    assign pndng_device2 = pndng[2];
    assign pndng_device3 = pndng[3];

    logic [PCKG_SZ-1:0] in_mem [4][DEPTH];
    ptr_t               in_rd  [4];
    ptr_t               in_wr  [4];
    cnt_t               in_cnt [4];

    logic [PCKG_SZ-1:0] eg_mem [4][DEPTH];
    ptr_t               eg_rd  [4];
    ptr_t               eg_wr  [4];
    cnt_t               eg_cnt [4];

    logic [PCKG_SZ-1:0] head [4];
    logic [3:0]         dest [4];
    logic [3:0]         in_we;
    logic [3:0]         in_re;
    logic [3:0]         eg_we;
    logic [3:0]         eg_pop;
    logic [3:0]         eg_space;
    logic [3:0]         cand;
    logic [1:0]         rr_ptr;
    logic [1:0]         gnt_idx;
    logic [1:0]         scan;
    logic               gnt_vld;
    logic [PCKG_SZ-1:0] gnt_data;

    // Invalid targets (4..6) route nowhere, so they are always eligible and vanish.
    function automatic logic [3:0] route(input logic [2:0] tgt, input logic [1:0] src);
        route = 4'b0000;
        if (tgt == BROADCAST)
            route = 4'hf & ~(4'b0001 << src);
        else if (!tgt[2])
            route = 4'b0001 << tgt[1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pndng[i]    = eg_cnt[i] != '0;
            dout[i]     = pndng[i] ? eg_mem[i][eg_rd[i]] : '0;
            eg_pop[i]   = pop[i] && pndng[i];
            eg_space[i] = (eg_cnt[i] != cnt_t'(DEPTH)) || eg_pop[i];
            in_we[i]    = push[i] && (in_cnt[i] != cnt_t'(DEPTH));
            head[i]     = in_mem[i][in_rd[i]];
            dest[i]     = route(head[i][PCKG_SZ-1 -: 3], 2'(i));
        end
        for (int i = 0; i < 4; i++)
            cand[i] = (in_cnt[i] != '0) && ((dest[i] & ~eg_space) == 4'b0000);
    end

    // Scan downward so the candidate nearest rr_ptr is the last one assigned.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_ptr;
        scan    = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            scan = rr_ptr + 2'(k);
            if (cand[scan]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan;
            end
        end
        gnt_data = head[gnt_idx];
        eg_we    = gnt_vld ? dest[gnt_idx] : 4'b0000;
        for (int i = 0; i < 4; i++)
            in_re[i] = gnt_vld && (gnt_idx == 2'(i));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (in_we[i])
                in_mem[i][in_wr[i]] <= din[i];
            if (eg_we[i])
                eg_mem[i][eg_wr[i]] <= gnt_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                in_rd[i]  <= '0;
                in_wr[i]  <= '0;
                in_cnt[i] <= '0;
                eg_rd[i]  <= '0;
                eg_wr[i]  <= '0;
                eg_cnt[i] <= '0;
            end
        end else begin
            if (gnt_vld)
                rr_ptr <= gnt_idx + 2'd1;
            for (int i = 0; i < 4; i++) begin
                if (in_we[i])
                    in_wr[i] <= in_wr[i] + ptr_t'(1);
                if (in_re[i])
                    in_rd[i] <= in_rd[i] + ptr_t'(1);
                in_cnt[i] <= in_cnt[i] + cnt_t'(in_we[i]) - cnt_t'(in_re[i]);
                if (eg_we[i])
                    eg_wr[i] <= eg_wr[i] + ptr_t'(1);
                if (eg_pop[i])
                    eg_rd[i] <= eg_rd[i] + ptr_t'(1);
                eg_cnt[i] <= eg_cnt[i] + cnt_t'(eg_we[i]) - cnt_t'(eg_pop[i]);
            end
        end
    end

endmodule

// File: tb/tb_top_bus.sv
// Directed self-checking bench for top_bus: reset, latency, broadcast,
// round-robin order, back-pressure, ingress overflow and invalid targets.
module tb_top_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  push;
    logic [3:0]  pop;
    logic [64:0] dpush [4];
    logic [64:0] dpop  [4];
    logic        pndng [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    top_bus dut (
        .clk(clk),
        .reset(reset),
        .push_device0(push[0]),
        .push_device1(push[1]),
        .push_device2(push[2]),
        .push_device3(push[3]),
        .D_push_device0(dpush[0]),
        .D_push_device1(dpush[1]),
        .D_push_device2(dpush[2]),
        .D_push_device3(dpush[3]),
        .pop_device0(pop[0]),
        .pop_device1(pop[1]),
        .pop_device2(pop[2]),
        .pop_device3(pop[3]),
        .D_pop_device0(dpop[0]),
        .D_pop_device1(dpop[1]),
        .D_pop_device2(dpop[2]),
        .D_pop_device3(dpop[3]),
        .pndng_device0(pndng[0]),
        .pndng_device1(pndng[1]),
        .pndng_device2(pndng[2]),
        .pndng_device3(pndng[3])
    );

    function automatic logic [64:0] mk(input logic [2:0] tgt, input logic [1:0] src,
                                       input logic [59:0] pay);
        return {tgt, src, pay};
    endfunction

    function automatic logic [64:0] pnd_vec();
        return {61'd0, pndng[3], pndng[2], pndng[1], pndng[0]};
    endfunction

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        pop   = 4'h0;
        push  = 4'hf;
        for (int i = 0; i < 4; i++)
            dpush[i] = mk(3'b111, 2'(i), 60'(i));

        // Reset held with pushes active
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_pndng", pnd_vec(), 65'd0);
            for (int i = 0; i < 4; i++)
                check("rst_dpop", dpop[i], 65'd0);
        end
        push  = 4'h0;
        reset = 1'b1;
        repeat (3) tick();
        check("post_rst_pndng", pnd_vec(), 65'd0);

        // Unicast latency
        push[0]  = 1'b1;
        dpush[0] = mk(3'd2, 2'd0, 60'h0);
        tick();
        push[0] = 1'b0;
        check("uni_e0_pndng", pnd_vec(), 65'd0);
        tick();
        check("uni_e1_pndng", pnd_vec(), 65'b0100);
        check("uni_dpop2", dpop[2], 65'h08000000000000000);
        pop[2] = 1'b1;
        tick();
        pop[2] = 1'b0;
        check("uni_popped", pnd_vec(), 65'd0);

        // Broadcast from device1
        push[1]  = 1'b1;
        dpush[1] = mk(3'b111, 2'd1, 60'hABC);
        tick();
        push[1] = 1'b0;
        tick();
        check("bc_pndng", pnd_vec(), 65'b1101);
        check("bc_d0", dpop[0], mk(3'b111, 2'd1, 60'hABC));
        check("bc_d1", dpop[1], 65'd0);
        check("bc_d2", dpop[2], mk(3'b111, 2'd1, 60'hABC));
        check("bc_d3", dpop[3], mk(3'b111, 2'd1, 60'hABC));
        pop = 4'b1101;
        tick();
        pop = 4'h0;
        check("bc_drained", pnd_vec(), 65'd0);

        // Round-robin from a fresh arbiter pointer
        reset = 1'b0;
        #1;
        check("rst_async_pndng", pnd_vec(), 65'd0);
        tick();
        reset = 1'b1;
        push = 4'hf;
        for (int i = 0; i < 4; i++)
            dpush[i] = mk(3'd3, 2'(i), 60'h100 + 60'(i));
        tick();
        push = 4'h0;
        tick();
        check("rr_first", dpop[3], mk(3'd3, 2'd0, 60'h100));
        repeat (3) tick();
        pop[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rr_order", dpop[3], mk(3'd3, 2'(i), 60'h100 + 60'(i)));
            tick();
        end
        pop[3] = 1'b0;
        check("rr_drained", pnd_vec(), 65'd0);

        push = 4'b1010;
        dpush[1] = mk(3'd3, 2'd1, 60'h111);
        dpush[3] = mk(3'd3, 2'd3, 60'h133);
        tick();
        push = 4'h0;
        repeat (2) tick();
        pop[3] = 1'b1;
        check("rr2_a", dpop[3], mk(3'd3, 2'd1, 60'h111));
        tick();
        check("rr2_b", dpop[3], mk(3'd3, 2'd3, 60'h133));
        tick();
        pop[3] = 1'b0;
        check("rr2_drained", pnd_vec(), 65'd0);

        // Back-pressure on egress 1
        for (int k = 0; k < 9; k++) begin
            push[0]  = 1'b1;
            dpush[0] = mk(3'd1, 2'd0, 60'h200 + 60'(k));
            tick();
        end
        push[0] = 1'b0;
        repeat (3) tick();
        push[2]  = 1'b1;
        dpush[2] = mk(3'd0, 2'd2, 60'h300);
        tick();
        push[2] = 1'b0;
        repeat (2) tick();
        check("bp_other_pndng", pnd_vec(), 65'b0011);
        check("bp_other_data", dpop[0], mk(3'd0, 2'd2, 60'h300));
        check("bp_head", dpop[1], mk(3'd1, 2'd0, 60'h200));
        pop = 4'b0011;
        tick();
        pop = 4'h0;
        check("bp_after_pop", dpop[1], mk(3'd1, 2'd0, 60'h201));
        check("bp_other_clr", pnd_vec(), 65'b0010);
        pop[1] = 1'b1;
        for (int k = 1; k < 9; k++) begin
            check("bp_drain", dpop[1], mk(3'd1, 2'd0, 60'h200 + 60'(k)));
            tick();
        end
        pop[1] = 1'b0;
        check("bp_empty", pnd_vec(), 65'd0);

        // Ingress overflow behind a full egress 2
        for (int k = 0; k < 8; k++) begin
            push[1]  = 1'b1;
            dpush[1] = mk(3'd2, 2'd1, 60'h400 + 60'(k));
            tick();
        end
        push[1] = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 9; k++) begin
            push[0]  = 1'b1;
            dpush[0] = mk(3'd2, 2'd0, 60'h500 + 60'(k));
            tick();
        end
        push[0] = 1'b0;
        repeat (2) tick();
        pop[2] = 1'b1;
        for (int n = 0; n < 16; n++) begin
            if (n < 8)
                check("ov_drain", dpop[2], mk(3'd2, 2'd1, 60'h400 + 60'(n)));
            else
                check("ov_drain", dpop[2], mk(3'd2, 2'd0, 60'h500 + 60'(n - 8)));
            tick();
        end
        pop[2] = 1'b0;
        repeat (2) tick();
        check("ov_dropped", pnd_vec(), 65'd0);

        // Invalid target is consumed and discarded
        push[3]  = 1'b1;
        dpush[3] = mk(3'd5, 2'd3, 60'hDEAD);
        tick();
        push[3] = 1'b0;
        repeat (3) tick();
        check("inv_pndng", pnd_vec(), 65'd0);
        push[3]  = 1'b1;
        dpush[3] = mk(3'd0, 2'd3, 60'h600);
        tick();
        push[3] = 1'b0;
        tick();
        check("inv_next_pndng", pnd_vec(), 65'b0001);
        check("inv_next_data", dpop[0], mk(3'd0, 2'd3, 60'h600));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/top_bus.md
Name: top_bus

Overview:
- Four-port packet bus (device0..device3).
- Each device pushes 65-bit packets into its own ingress FIFO.
- A round-robin arbiter moves at most one packet per clock from an ingress FIFO to the egress FIFO(s) addressed by the packet header: unicast or broadcast.
- Each device drains its egress FIFO with a pending/pop handshake; the block is the interconnect between the four device-side agents.

Parameters:
- PCKG_SZ, 65, packet width in bits.
- DEPTH, 8, entries per ingress and per egress FIFO (power of 2, >=2).
- BROADCAST, 3'b111, target id meaning "all devices except sender".

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- push_deviceN (N=0..3)  input  1  write D_push_deviceN into ingress FIFO N.
- D_push_deviceN  input  65  packet from device N.
- pop_deviceN  input  1  device N consumes head of egress FIFO N.
- D_pop_deviceN  output  65  head of egress FIFO N (first-word-fall-through).
- pndng_deviceN  output  1  egress FIFO N non-empty.

Behaviour:
- Packet format:
  - [64:62] target id.
  - [61:60] source id (informational, forwarded unchanged).
  - [59:0] payload.
  - Packets are delivered bit-exact.
- Reset (reset=0, async):
  - All FIFOs empty; pointers/counters cleared.
  - Arbiter pointer set so device0 has highest priority.
  - pndng_deviceN=0 and D_pop_deviceN=0 immediately; held while reset=0.
  - Reset mid-operation discards all in-flight packets.
- Ingress:
  - push_deviceN=1 at a rising edge writes D_push_deviceN.
  - Push into a full ingress FIFO is dropped silently; contents are unchanged.
- Arbitration, each edge:
  - Candidates are the non-empty ingress FIFOs whose destination egress FIFO(s) all have space, counting a pop occurring that same edge as freeing space.
  - Grant the first candidate searching from (last granted + 1) mod 4; first after reset is device0.
  - Granted packet is popped from ingress and written to its destination egress FIFO(s) on the same edge.
  - No candidate: no transfer; pointer unchanged.
  - A blocked head-of-line packet stalls only its own ingress FIFO; others continue.
- Routing:
  - Target 0..3: unicast to egress FIFO of that id, including the sender's own id (loopback allowed).
  - Target 7: write to all egress FIFOs except the one with the same index as the granting ingress port.
  - Targets 4..6: packet consumed from ingress and discarded; no output effect.
- Latency: push at edge E0; earliest transfer at E1; pndng_device(target)=1 and D_pop valid after E1. Minimum two edges.
- Egress:
  - pndng_deviceN = egress N non-empty.
  - D_pop_deviceN = head entry, or 0 when empty.
  - pop_deviceN=1 at an edge with pndng=1 removes the head; D_pop shows the next entry after that edge.
  - Pop on empty is ignored.
  - Simultaneous bus write and pop on the same egress FIFO are both performed; the count is unchanged.
- Ordering:
  - FIFO order per ingress is preserved.
  - Packets from different sources to one destination arrive in grant order.
- No packet is ever duplicated to one port or lost once accepted into ingress, except the invalid-target discard.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 for 3 cycles with pushes active, then release.
  - Required: all pndng=0 and D_pop=0 during reset; nothing delivered from pushes made during reset.
- Unicast latency:
  - Stimulus: device0 pushes {3'd2,2'd0,60'h0} once.
  - Required: pndng_device2=1 two edges later with D_pop_device2=65'h08000000000000000; other pndng stay 0; pop_device2=1 for one cycle clears pndng_device2.
- Broadcast:
  - Stimulus: device1 pushes target 3'b111, payload 60'hABC.
  - Required: devices 0, 2 and 3 each receive the identical packet; device1 receives nothing.
- Round-robin:
  - Stimulus: devices 0..3 all push to target 3 in the same cycle.
  - Required: egress 3 receives in order source 0, 1, 2, 3, one per cycle.
  - Then repeat with devices 1 and 3 only; required order 1, 3.
- Back-pressure:
  - Stimulus: fill egress 1 with DEPTH packets with pop_device1 held 0, then push a 9th.
  - Required: the 9th stays in ingress; other ports' traffic unaffected.
  - Assert pop_device1 once; the 9th arrives in the following cycle.
- Overflow and invalid target:
  - Stimulus: push DEPTH+1 packets into device0 ingress while egress is blocked; separately push target 3'd5.
  - Required: the extra packet is dropped (exactly DEPTH delivered after unblock); the target-5 packet produces no pndng on any port.
